// File: rtl/dsp_mac_pipe.sv
// Four-stage pipelined pre-add / multiply / post-add slice with valid tracking,
// global clock enable, optional signed saturation and sticky overflow.
module dsp_mac_pipe #(
  parameter int A_W    = 18,
  parameter int B_W    = 18,
  parameter int P_W    = 48,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [B_W-1:0] d,
  input  logic signed [P_W-1:0] c,
  input  logic                  cin,
  input  logic [3:0]            opmode,
  input  logic                  clr_sticky,
  output logic signed [P_W-1:0] p,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam int XW = B_W + 1;
  localparam int MW = A_W + B_W + 1;
  localparam int RW = P_W + 1;

  // stage 1: input capture
  logic signed [A_W-1:0] a1;
  logic signed [B_W-1:0] b1, d1;
  logic signed [P_W-1:0] c1;
  logic                  cin1, v1;
  logic [3:0]            op1;

  // stage 2: pre-adder result
  logic signed [A_W-1:0] a2;
  logic signed [XW-1:0]  x2;
  logic signed [P_W-1:0] c2;
  logic                  cin2, v2;
  logic [1:0]            op2;

  // stage 3: product
  logic signed [MW-1:0]  m3;
  logic signed [P_W-1:0] c3;
  logic                  cin3, v3;
  logic [1:0]            op3;

  logic signed [XW-1:0]  bx, dx, x_next;
  logic signed [MW-1:0]  ax, xx, m_next;
  logic signed [P_W-1:0] z;
  logic signed [RW-1:0]  zx, mx, cx, r;
  logic signed [P_W-1:0] p_next;
  logic                  ovf_next;

  // Pre-adder is one bit wider than B/D so it can never wrap.
  always_comb begin
    bx     = {b1[B_W-1], b1};
    dx     = {d1[B_W-1], d1};
    x_next = bx;
    if (op1[0])
      x_next = op1[1] ? (dx - bx) : (bx + dx);
  end

  always_comb begin
    ax     = {{(MW-A_W){a2[A_W-1]}}, a2};
    xx     = {{(MW-XW){x2[XW-1]}}, x2};
    m_next = ax * xx;
  end

  // Post-adder at P_W+1 bits; disagreement of the top two bits means overflow.
  always_comb begin
    z        = op3[0] ? p : c3;
    zx       = {z[P_W-1], z};
    mx       = {{(RW-MW){m3[MW-1]}}, m3};
    cx       = {{P_W{1'b0}}, cin3};
    r        = op3[1] ? (zx - mx + cx) : (zx + mx + cx);
    ovf_next = r[P_W] ^ r[P_W-1];
    p_next   = r[P_W-1:0];
    if (SAT_EN && ovf_next)
      p_next = r[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; cin1 <= 1'b0; op1 <= '0; v1 <= 1'b0;
      a2 <= '0; x2 <= '0; c2 <= '0; cin2 <= 1'b0; op2 <= '0; v2 <= 1'b0;
      m3 <= '0; c3 <= '0; cin3 <= 1'b0; op3 <= '0; v3 <= 1'b0;
      p         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      a1 <= a; b1 <= b; d1 <= d; c1 <= c; cin1 <= cin; op1 <= opmode; v1 <= in_valid;
      a2 <= a1; x2 <= x_next; c2 <= c1; cin2 <= cin1; op2 <= op1[3:2]; v2 <= v1;
      m3 <= m_next; c3 <= c2; cin3 <= cin2; op3 <= op2; v3 <= v2;
      out_valid <= v3;
      ovf       <= v3 & ovf_next;
      if (v3)
        p <= p_next;
    end else begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end
  end

  // Clear is independent of ce; a simultaneous new overflow takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (ce && v3 && ovf_next)
      ovf_sticky <= 1'b1;
    else if (clr_sticky)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed self-checking bench for dsp_mac_pipe; a second instance with
// SAT_EN=0 shares the stimulus to check wrap-around behaviour.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [17:0] a = '0, b = '0, d = '0;
  logic signed [47:0] c = '0;
  logic               cin = 1'b0;
  logic [3:0]         opmode = '0;
  logic               clr_sticky = 1'b0;

  logic signed [47:0] p, p_w;
  logic               out_valid, ovf, ovf_sticky;
  logic               out_valid_w, ovf_w, ovf_sticky_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .cin(cin), .opmode(opmode),
    .clr_sticky(clr_sticky),
    .p(p), .out_valid(out_valid), .ovf(ovf), .ovf_sticky(ovf_sticky)
  );

  dsp_mac_pipe #(.A_W(18), .B_W(18), .P_W(48), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .cin(cin), .opmode(opmode),
    .clr_sticky(clr_sticky),
    .p(p_w), .out_valid(out_valid_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [17:0] ai, input logic signed [17:0] bi,
                       input logic signed [17:0] di, input logic signed [47:0] ci,
                       input logic cii, input logic [3:0] op);
    in_valid = v; a = ai; b = bi; d = di; c = ci; cin = cii; opmode = op;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (p !== 48'sd0) begin errors++; $display("[TB] FAIL reset_p got %h want 0", p); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky got %b want 0", ovf_sticky); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_accumulate();
    logic pattern [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic signed [47:0] expv [3] = '{48'sd6, 48'sd12, 48'sd18};
    int n = 0;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      drive(pattern[i], 18'sd2, 18'sd3, 18'sd0, 48'sd0, 1'b0, 4'b0100);
      step();
      if (i == 4) begin
        checks++;
        if (out_valid !== 1'b0 || p !== 48'sd6) begin
          errors++;
          $display("[TB] FAIL acc_bubble_hold got v=%b p=%0d want v=0 p=6", out_valid, p);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (n >= 3) begin
          errors++; $display("[TB] FAIL acc_extra_strobe got p=%0d want no strobe", p);
        end else if (p !== expv[n]) begin
          errors++; $display("[TB] FAIL acc_value%0d got %0d want %0d", n, p, expv[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("[TB] FAIL acc_count got %0d want 3", n); end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
  endtask

  task automatic test_preadd();
    drive(1'b1, 18'sd3, 18'sd6, 18'sd4, 48'sd9, 1'b1, 4'b0001);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL preadd_early got %b want 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL preadd_valid got %b want 1", out_valid); end
    checks++;
    if (p !== 48'sh28) begin errors++; $display("[TB] FAIL preadd_p got %h want 28", p); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL preadd_ovf got %b want 0", ovf); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL preadd_single_strobe got %b want 0", out_valid); end
  endtask

  task automatic test_presub();
    drive(1'b1, 18'sd5, 18'sd7, 18'sd8, 48'sh10, 1'b0, 4'b1011);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b1 || p !== 48'sh0B) begin
      errors++; $display("[TB] FAIL presub_p got v=%b p=%h want v=1 p=0b", out_valid, p);
    end
  endtask

  task automatic test_stall();
    logic vpat [13] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic cpat [13] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic signed [47:0] expv [4] = '{48'sd2, 48'sd104, 48'sd206, 48'sd308};
    int k = 0;
    int n = 0;
    for (int i = 0; i < 13; i++) begin
      ce = cpat[i];
      if (vpat[i]) begin
        drive(1'b1, 18'(k + 1), 18'sd2, 18'sd0, 48'(100 * k), 1'b0, 4'b0000);
        k++;
      end else begin
        drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
      end
      step();
      if (out_valid === 1'b1) begin
        checks++;
        if (n >= 4) begin
          errors++; $display("[TB] FAIL stall_extra_strobe got p=%0d want none", p);
        end else if (p !== expv[n]) begin
          errors++; $display("[TB] FAIL stall_value%0d got %0d want %0d", n, p, expv[n]);
        end
        n++;
      end
    end
    ce = 1'b1;
    checks++;
    if (n != 4) begin errors++; $display("[TB] FAIL stall_count got %0d want 4", n); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 1'b0, 4'b0000);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
    step(); step(); step();
    checks++;
    if (p !== 48'sh7FFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL sat_p got %h want 7fffffffffff", p); end
    checks++;
    if (ovf !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_ovf got ovf=%b v=%b want 1 1", ovf, out_valid);
    end
    checks++;
    if (p_w !== 48'sh8000_0000_0000) begin errors++; $display("[TB] FAIL wrap_p got %h want 800000000000", p_w); end
    step();
    checks++;
    if (ovf !== 1'b0 || ovf_sticky !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_sticky got ovf=%b sticky=%b want 0 1", ovf, ovf_sticky);
    end
    ce = 1'b0;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    ce = 1'b1;
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL sticky_clear got %b want 0", ovf_sticky); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 1'b0, 4'b0000);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 18'sd2, 18'sd2, 18'sd0, 48'sd1, 1'b0, 4'b0000);
      step();
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 4'b0000);
    checks++;
    if (out_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
      errors++; $display("[TB] FAIL arst_pre got v=%b sticky=%b want 1 1", out_valid, ovf_sticky);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (p !== 48'sd0) begin errors++; $display("[TB] FAIL arst_p got %h want 0", p); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got %b want 0", out_valid); end
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL arst_sticky got %b want 0", ovf_sticky); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || p !== 48'sd0) begin
        errors++; $display("[TB] FAIL arst_stale%0d got v=%b p=%h want v=0 p=0", i, out_valid, p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_preadd();
    test_presub();
    test_stall();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, fully pipelined pre-add / multiply / post-add engine. It is the next-generation arithmetic slice for the datapath, generalising the fixed 18x18/48-bit DSP slice. New behaviour over that slice:
- configurable operand and accumulator widths
- a valid pipeline with a global stall (CE)
- signed saturation with per-result and sticky overflow flags

It sits between operand sequencers and result FIFOs in filter and MAC chains.

## Interface
- A_W, 18, width of signed operand A
- B_W, 18, width of signed operands B and D
- P_W, 48, width of signed C, P and accumulator; must be >= A_W+B_W+2
- SAT_EN, 1, 1 = saturate post-adder result; 0 = wrap (two's complement)
- CLK  in  1  clock; all registers update on its rising edge
- RST  in  1  reset, asynchronous, active-high; clears every register
- CE  in  1  global clock enable; 0 stalls the whole pipeline
- IN_VALID  in  1  qualifies A, B, D, C, OPMODE, CIN this cycle
- A  in  A_W  signed multiplier operand
- B  in  B_W  signed pre-adder operand
- D  in  B_W  signed pre-adder operand
- C  in  P_W  signed post-adder load operand
- CIN  in  1  post-adder carry-in
- OPMODE  in  4  [0] pre-add enable, [1] pre-sub (D-B), [2] accumulate (Z=P, else Z=C), [3] post-sub (Z-M)
- P  out  P_W  signed result register
- OUT_VALID  out  1  one-cycle strobe: P holds a new result
- OVF  out  1  overflow occurred on the result currently strobed
- OVF_STICKY  out  1  OR of all OVF since reset
- CLR_STICKY  in  1  synchronous clear of OVF_STICKY (honoured regardless of CE)

## Operation
- S1: register A, B, D, C, CIN, OPMODE and IN_VALID as v1.
- S2: pre-adder, computed at B_W+1 bits (no wrap), then registered; v2.
  - OPMODE[0]=0: X = sign-extended B.
  - OPMODE[0]=1: X = B+D, or D-B when OPMODE[1]=1.
- S3: M = A * X, signed, A_W+B_W+1 bits, registered; v3. C, CIN and OPMODE travel alongside.
- S4: post-add, computed at P_W+1 bits.
  - Z = P when OPMODE[2]=1, else C.
  - R = Z + sext(M) + CIN, or Z - sext(M) + CIN when OPMODE[3]=1.
- Overflow: R does not fit in P_W signed bits.
  - SAT_EN=1: P = +max (0111..1) or -max (1000..0) by sign of R.
  - SAT_EN=0: P = R[P_W-1:0].
- P, OVF and OUT_VALID update only when v3=1 and CE=1. A bubble (v3=0) leaves P unchanged, so accumulation skips bubbles.
- Accumulate reads the current P register, so back-to-back valid accumulate inputs chain correctly with no hazard.
- OVF_STICKY: set when a strobed OVF=1; cleared by CLR_STICKY. Set wins on a simultaneous set and clear.

## Timing
- Latency: inputs sampled with IN_VALID=1 and CE=1 at edge n give OUT_VALID=1 and P valid after edge n+3, i.e. 4 edges including the sampling edge.
- Throughput: one result per cycle.
- CE=0 at an edge:
  - every data and valid register holds, except OUT_VALID and OVF, which clear to 0;
  - a result is strobed exactly once; stalls never duplicate or drop results.
- RST asserted (any time, mid-stream included):
  - immediately clears P, M, X, all stage registers, v1..v3, OUT_VALID, OVF and OVF_STICKY to 0;
  - in-flight operations are discarded;
  - after RST releases, the first OUT_VALID is no earlier than 4 edges after the first accepted input.
- Reset value of every output is 0.

## Test plan
- Pre-add MAC: A=3, B=6, D=4, C=9, CIN=1, OPMODE=0001 -> after 4 edges OUT_VALID=1, P=0x28 (30+9+1), OVF=0.
- Pre-sub / post-sub: A=5, B=7, D=8, C=0x10, CIN=0, OPMODE=1011 -> P=0x0B (16-5).
- Accumulate with bubbles: IN_VALID pattern 1,0,1,1, each A=2, B=3, OPMODE=0100, C=0 after reset -> OUT_VALID strobes show P=6, 12, 18; P holds 6 during the bubble.
- Stall: assert CE=0 for 3 cycles mid-stream of 4 valid inputs -> exactly 4 OUT_VALID strobes in order, values unchanged versus the no-stall run.
- Saturation: SAT_EN=1, C=0x7FFF_FFFF_FFFF, A=1, B=1, OPMODE=0000, CIN=0 -> P=0x7FFF_FFFF_FFFF, OVF=1, OVF_STICKY=1. Then CLR_STICKY -> OVF_STICKY=0. With SAT_EN=0 -> P=0x8000_0000_0000.
- Async reset mid-pipeline: pulse RST between edges with 3 operations in flight -> P, OUT_VALID and OVF_STICKY drop to 0 immediately and no stale strobe follows.
